// File: rtl/pf_refill_arbiter_if.sv
// Handshake bundle between the refill arbiter, the cache miss path, the prefetcher and memory.
// The master modport is the arbiter's view; slave is the surrounding environment's view.
interface pf_refill_arbiter_if #(
    parameter int LINE_WIDTH = 256,
    parameter int BEAT_WIDTH = 32
);
    logic                  dm_req_valid;
    logic [31:0]           dm_req_addr;
    logic                  dm_req_ready;
    logic                  dm_resp_valid;
    logic [LINE_WIDTH-1:0] dm_resp_data;
    logic                  pf_valid;
    logic [31:0]           pf_addr;
    logic                  pf_answer;
    logic                  pf_fill_valid;
    logic [31:0]           pf_fill_addr;
    logic [LINE_WIDTH-1:0] pf_fill_data;
    logic                  mem_rd_req;
    logic [31:0]           mem_rd_addr;
    logic                  mem_rd_gnt;
    logic                  mem_rd_valid;
    logic [BEAT_WIDTH-1:0] mem_rd_data;

    modport master (
        input  dm_req_valid, dm_req_addr, pf_valid, pf_addr,
               mem_rd_gnt, mem_rd_valid, mem_rd_data,
        output dm_req_ready, dm_resp_valid, dm_resp_data,
               pf_answer, pf_fill_valid, pf_fill_addr, pf_fill_data,
               mem_rd_req, mem_rd_addr
    );

    modport slave (
        output dm_req_valid, dm_req_addr, pf_valid, pf_addr,
               mem_rd_gnt, mem_rd_valid, mem_rd_data,
        input  dm_req_ready, dm_resp_valid, dm_resp_data,
               pf_answer, pf_fill_valid, pf_fill_addr, pf_fill_data,
               mem_rd_req, mem_rd_addr
    );
endinterface

// File: rtl/pf_refill_arbiter.sv
// Shares one line-refill read port between demand misses (priority) and prefetches,
// merging a demand into an in-flight prefetch of the same line.
module pf_refill_arbiter #(
    parameter int LINE_WIDTH = 256,
    parameter int BEAT_WIDTH = 32
) (
    input  logic                clk,
    input  logic                reset,
    pf_refill_arbiter_if.master bus
);
    localparam int BEATS    = LINE_WIDTH / BEAT_WIDTH;
    localparam int OFF_BITS = $clog2(LINE_WIDTH / 8);
    localparam int CNT_W    = $clog2(BEATS);
    localparam logic [31:0] OFF_MASK = 32'((1 << OFF_BITS) - 1);

    typedef enum logic [2:0] {IDLE, DM_REQ, DM_DATA, PF_REQ, PF_DATA, RESP} state_t;

    state_t                state, state_next;
    logic [31:0]           line_addr;
    logic [CNT_W-1:0]      beat_cnt;
    logic                  merged;
    logic                  xfer_pf;
    logic [LINE_WIDTH-1:0] line_buf;
    logic [LINE_WIDTH-1:0] line_next;
    logic [LINE_WIDTH-1:0] resp_data;
    logic [31:0]           fill_addr;

    logic dm_ready, answer, rd_req;
    logic accept_dm, accept_pf, merge_hit, beat_en, last_beat;

    function automatic logic [31:0] line_of(input logic [31:0] a);
        return a & ~OFF_MASK;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        dm_ready   = 1'b0;
        answer     = 1'b0;
        rd_req     = 1'b0;
        accept_dm  = 1'b0;
        accept_pf  = 1'b0;
        merge_hit  = 1'b0;
        beat_en    = 1'b0;
        last_beat  = (beat_cnt == CNT_W'(BEATS - 1));
        case (state)
            IDLE: begin
                if (bus.dm_req_valid) begin
                    dm_ready   = 1'b1;
                    accept_dm  = 1'b1;
                    state_next = DM_REQ;
                    // A same-line prefetch is redundant with the demand: answer and drop it.
                    answer = bus.pf_valid && (line_of(bus.pf_addr) == line_of(bus.dm_req_addr));
                end else if (bus.pf_valid) begin
                    answer     = 1'b1;
                    accept_pf  = 1'b1;
                    state_next = PF_REQ;
                end
            end
            DM_REQ, PF_REQ: begin
                rd_req = 1'b1;
                if (bus.mem_rd_gnt) state_next = (state == DM_REQ) ? DM_DATA : PF_DATA;
            end
            DM_DATA, PF_DATA: begin
                beat_en = bus.mem_rd_valid;
                if (beat_en && last_beat) state_next = RESP;
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if ((state == PF_REQ || state == PF_DATA) && bus.dm_req_valid && !merged &&
            line_of(bus.dm_req_addr) == line_addr) begin
            merge_hit = 1'b1;
            dm_ready  = 1'b1;
        end
        if (reset) begin
            dm_ready = 1'b0;
            answer   = 1'b0;
            rd_req   = 1'b0;
        end
    end

    always_comb begin
        line_next = line_buf;
        for (int i = 0; i < BEATS; i++) begin
            if (beat_cnt == CNT_W'(i)) line_next[i*BEAT_WIDTH +: BEAT_WIDTH] = bus.mem_rd_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            line_addr <= '0;
            beat_cnt  <= '0;
            merged    <= 1'b0;
            xfer_pf   <= 1'b0;
            resp_data <= '0;
            fill_addr <= '0;
        end else begin
            if (accept_dm) begin
                line_addr <= line_of(bus.dm_req_addr);
                xfer_pf   <= 1'b0;
            end else if (accept_pf) begin
                line_addr <= line_of(bus.pf_addr);
                xfer_pf   <= 1'b1;
            end
            if (merge_hit)          merged <= 1'b1;
            else if (state == RESP) merged <= 1'b0;
            if (beat_en) begin
                beat_cnt <= beat_cnt + CNT_W'(1);
                // Capture the completed line so outputs hold steady while the next refill assembles.
                if (last_beat) begin
                    resp_data <= line_next;
                    if (xfer_pf) fill_addr <= line_addr;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (beat_en) line_buf <= line_next;
    end

    assign bus.dm_req_ready  = dm_ready;
    assign bus.pf_answer     = answer;
    assign bus.mem_rd_req    = rd_req;
    assign bus.mem_rd_addr   = rd_req ? line_addr : '0;
    assign bus.dm_resp_valid = !reset && (state == RESP) && (!xfer_pf || merged);
    assign bus.pf_fill_valid = !reset && (state == RESP) && xfer_pf;
    assign bus.dm_resp_data  = resp_data;
    assign bus.pf_fill_data  = resp_data;
    assign bus.pf_fill_addr  = fill_addr;
endmodule
